// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions. Resolves the oldest entry, drives the
// predictor-table update strobe, flushes on mispredict and keeps saturating statistics.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [IDX_W-1:0]       push_idx,
  input  logic                   push_pred,
  input  logic                   resolve,
  input  logic                   resolve_taken,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   upd_branch,
  output logic                   upd_taken,
  output logic [IDX_W-1:0]       upd_idx,
  output logic                   mispredict,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       mispred_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [IDX_W-1:0] idx_mem_q [DEPTH];
  logic [DEPTH-1:0] pred_mem_q;

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    count_q, count_d;

  logic             push_ok, res_ok, res_mis;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign count = count_q;

  assign head_idx  = idx_mem_q[rd_ptr_q];
  assign head_pred = pred_mem_q[rd_ptr_q];

  assign push_ok = push & ~full;
  assign res_ok  = resolve & ~empty;
  assign res_mis = res_ok & (head_pred != resolve_taken);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (res_mis) begin
      // Everything younger than the mispredicted branch is wrong-path: drop it all.
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      wr_ptr_d = rd_ptr_q + PtrW'(1);
      count_d  = '0;
    end else begin
      if (res_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d = count_q + (PtrW + 1)'(push_ok) - (PtrW + 1)'(res_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !res_mis) begin
      idx_mem_q[wr_ptr_q]  <= push_idx;
      pred_mem_q[wr_ptr_q] <= push_pred;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_branch <= 1'b0;
      upd_taken  <= 1'b0;
      upd_idx    <= '0;
      mispredict <= 1'b0;
    end else begin
      upd_branch <= res_ok;
      mispredict <= res_mis;
      if (res_ok) begin
        upd_idx   <= head_idx;
        upd_taken <= resolve_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_ok && (branch_cnt != '1))   branch_cnt  <= branch_cnt + CNT_W'(1);
      if (res_mis && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, corner sequences and random traffic
// checked against a queue-based reference model. A CNT_W=3 copy exercises counter saturation.
module tb_branch_resolve_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, push_pred, resolve, resolve_taken;
  logic [3:0] push_idx;

  logic        full, empty, upd_branch, upd_taken, mispredict;
  logic [2:0]  count;
  logic [3:0]  upd_idx;
  logic [15:0] branch_cnt, mispred_cnt;

  logic       s_full, s_empty, s_upd_branch, s_upd_taken, s_mispredict;
  logic [2:0] s_count;
  logic [3:0] s_upd_idx;
  logic [2:0] s_branch_cnt, s_mispred_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_resolve_queue #(.DEPTH(4), .IDX_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .push(push), .push_idx(push_idx), .push_pred(push_pred),
    .resolve(resolve), .resolve_taken(resolve_taken), .full(full), .empty(empty),
    .count(count), .upd_branch(upd_branch), .upd_taken(upd_taken), .upd_idx(upd_idx),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_queue #(.DEPTH(4), .IDX_W(4), .CNT_W(3)) dut_small (
    .clk(clk), .reset(reset), .push(push), .push_idx(push_idx), .push_pred(push_pred),
    .resolve(resolve), .resolve_taken(resolve_taken), .full(s_full), .empty(s_empty),
    .count(s_count), .upd_branch(s_upd_branch), .upd_taken(s_upd_taken),
    .upd_idx(s_upd_idx), .mispredict(s_mispredict), .branch_cnt(s_branch_cnt),
    .mispred_cnt(s_mispred_cnt)
  );

  // Reference model: a plain queue of {idx, pred} plus expected registered outputs.
  typedef struct packed {
    logic [3:0] idx;
    logic       pred;
  } ent_t;

  ent_t       mq[$];
  logic       m_ub, m_ut, m_mis;
  logic [3:0] m_ui;
  int         m_bc, m_mc, m_sbc, m_smc;

  task automatic model_reset();
    mq.delete();
    m_ub = 0; m_ut = 0; m_mis = 0; m_ui = 0;
    m_bc = 0; m_mc = 0; m_sbc = 0; m_smc = 0;
  endtask

  task automatic model_step(input logic p, input logic [3:0] i, input logic pr,
                            input logic r, input logic t);
    ent_t head;
    bit   push_ok, res_ok;
    push_ok = p && (mq.size() != 4);
    res_ok  = r && (mq.size() != 0);
    m_ub  = res_ok;
    m_mis = 0;
    if (res_ok) begin
      head  = mq.pop_front();
      m_ui  = head.idx;
      m_ut  = t;
      m_mis = (head.pred != t);
      if (m_bc < 65535) m_bc++;
      if (m_sbc < 7) m_sbc++;
      if (m_mis) begin
        if (m_mc < 65535) m_mc++;
        if (m_smc < 7) m_smc++;
      end
    end
    if (m_mis) mq.delete();
    else if (push_ok) mq.push_back('{idx: i, pred: pr});
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == 4);
    chk("upd_branch", upd_branch, m_ub);
    chk("upd_idx", upd_idx, m_ui);
    chk("upd_taken", upd_taken, m_ut);
    chk("mispredict", mispredict, m_mis);
    chk("branch_cnt", branch_cnt, m_bc);
    chk("mispred_cnt", mispred_cnt, m_mc);
    chk("s_count", s_count, mq.size());
    chk("s_empty", s_empty, mq.size() == 0);
    chk("s_full", s_full, mq.size() == 4);
    chk("s_upd_branch", s_upd_branch, m_ub);
    chk("s_upd_idx", s_upd_idx, m_ui);
    chk("s_upd_taken", s_upd_taken, m_ut);
    chk("s_mispredict", s_mispredict, m_mis);
    chk("s_branch_cnt", s_branch_cnt, m_sbc);
    chk("s_mispred_cnt", s_mispred_cnt, m_smc);
  endtask

  task automatic step(input logic p, input logic [3:0] i, input logic pr,
                      input logic r, input logic t);
    @(negedge clk);
    push = p; push_idx = i; push_pred = pr; resolve = r; resolve_taken = t;
    model_step(p, i, pr, r, t);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    push = 0; resolve = 0;
    model_reset();
    @(negedge clk);
    reset = 0;
    #1;
    check_all();
  endtask

  typedef struct {
    logic       p;
    logic [3:0] i;
    logic       pr;
    logic       r;
    logic       t;
    logic       e_ub;
    logic [3:0] e_ui;
    logic       e_mis;
    int         e_cnt;
  } vec_t;

  vec_t vt[$];

  initial begin
    reset = 1; push = 0; push_idx = 0; push_pred = 0; resolve = 0; resolve_taken = 0;
    model_reset();
    #1;
    check_all();
    do_reset();

    // {push, idx, pred, resolve, taken} -> {upd_branch, upd_idx, mispredict, count}
    vt.push_back('{1, 3, 1, 0, 0, 0, 3'd0, 0, 1});
    vt.push_back('{0, 0, 0, 1, 1, 1, 3, 0, 0});
    vt.push_back('{1, 1, 0, 0, 0, 0, 3, 0, 1});
    vt.push_back('{1, 2, 0, 0, 0, 0, 3, 0, 2});
    vt.push_back('{1, 3, 0, 0, 0, 0, 3, 0, 3});
    vt.push_back('{1, 4, 0, 0, 0, 0, 3, 0, 4});
    vt.push_back('{1, 5, 0, 0, 0, 0, 3, 0, 4});
    vt.push_back('{0, 0, 0, 1, 0, 1, 1, 0, 3});
    vt.push_back('{0, 0, 0, 1, 0, 1, 2, 0, 2});
    vt.push_back('{0, 0, 0, 1, 0, 1, 3, 0, 1});
    vt.push_back('{0, 0, 0, 1, 0, 1, 4, 0, 0});
    vt.push_back('{1, 5, 0, 0, 0, 0, 4, 0, 1});
    vt.push_back('{1, 6, 1, 0, 0, 0, 4, 0, 2});
    vt.push_back('{1, 7, 1, 0, 0, 0, 4, 0, 3});
    vt.push_back('{0, 0, 0, 1, 1, 1, 5, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 5, 0, 0});
    vt.push_back('{0, 0, 0, 1, 1, 0, 5, 0, 0});
    vt.push_back('{1, 8, 0, 0, 0, 0, 5, 0, 1});
    vt.push_back('{1, 9, 0, 0, 0, 0, 5, 0, 2});
    vt.push_back('{1, 10, 0, 0, 0, 0, 5, 0, 3});
    vt.push_back('{1, 11, 0, 0, 0, 0, 5, 0, 4});
    vt.push_back('{1, 12, 0, 1, 0, 1, 8, 0, 3});
    vt.push_back('{0, 0, 0, 1, 0, 1, 9, 0, 2});
    vt.push_back('{0, 0, 0, 1, 0, 1, 10, 0, 1});
    vt.push_back('{0, 0, 0, 1, 0, 1, 11, 0, 0});
    vt.push_back('{1, 13, 1, 1, 1, 0, 11, 0, 1});
    vt.push_back('{0, 0, 0, 1, 1, 1, 13, 0, 0});

    foreach (vt[k]) begin
      step(vt[k].p, vt[k].i, vt[k].pr, vt[k].r, vt[k].t);
      chk($sformatf("vec%0d_upd_branch", k), upd_branch, vt[k].e_ub);
      chk($sformatf("vec%0d_upd_idx", k), upd_idx, vt[k].e_ui);
      chk($sformatf("vec%0d_mispredict", k), mispredict, vt[k].e_mis);
      chk($sformatf("vec%0d_count", k), count, vt[k].e_cnt);
    end
    chk("tbl_branch_cnt", branch_cnt, 11);
    chk("tbl_mispred_cnt", mispred_cnt, 1);

    // Ten fill/drain rounds walk the pointers around the ring several times.
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 4; k++) step(1, 4'((c * 4 + k) % 16), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
        step(0, 0, 0, 1, 0);
        chk("wrap_idx", upd_idx, (c * 4 + k) % 16);
      end
    end

    // Saturation of the 3-bit counters: nine push/mispredicting-resolve pairs.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1, 4'(k), 1'b0, 1'b0, 1'b0);
      step(0, 0, 0, 1, 1);
    end
    chk("sat_mispred_cnt", s_mispred_cnt, 7);
    chk("sat_branch_cnt", s_branch_cnt, 7);
    chk("wide_mispred_cnt", mispred_cnt, 9);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Random traffic; outcomes mostly agree with the stored prediction.
    for (int n = 0; n < 400; n++) begin
      logic p, pr, r, t;
      p  = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      if (mq.size() != 0) t = mq[0].pred ^ ($urandom_range(0, 5) == 0);
      else t = 1'($urandom_range(0, 1));
      step(p, 4'($urandom_range(0, 15)), pr, r, t);
    end

    // Asynchronous reset mid-stream with two entries queued.
    do_reset();
    step(1, 4'd2, 1'b1, 1'b0, 1'b0);
    step(1, 4'd9, 1'b0, 1'b1, 1'b1);
    step(1, 4'd6, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_count", count, 2);
    @(negedge clk);
    push = 0; resolve = 0;
    #2;
    reset = 1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_upd_branch", upd_branch, 0);
    chk("arst_upd_idx", upd_idx, 0);
    chk("arst_upd_taken", upd_taken, 0);
    chk("arst_mispredict", mispredict, 0);
    chk("arst_branch_cnt", branch_cnt, 0);
    chk("arst_mispred_cnt", mispred_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 0;
    step(1, 4'd14, 1'b0, 1'b0, 1'b0);
    step(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight branch predictions, between fetch (which reads `prediction` from the saturating-counter predictor) and execute (which resolves branches).
- On each resolution it compares the actual outcome with the stored prediction.
- It drives the registered update strobe (branch/taken/index) into the saturating-counter table and raises a one-cycle mispredict flush.
- It keeps saturating statistics counters for total branches and mispredictions.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- IDX_W, 4, width of the predictor-table index stored per entry.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  fetch enqueues a predicted branch this cycle.
- push_idx  input  IDX_W  predictor-table index of the pushed branch.
- push_pred  input  1  prediction given for the pushed branch (1 = taken).
- resolve  input  1  execute resolves the oldest branch this cycle.
- resolve_taken  input  1  actual outcome of the oldest branch.
- full  output  1  queue holds DEPTH entries.
- empty  output  1  queue holds 0 entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- upd_branch  output  1  registered update strobe to the counter table.
- upd_taken  output  1  registered actual outcome that goes with upd_branch.
- upd_idx  output  IDX_W  registered table index that goes with upd_branch.
- mispredict  output  1  registered one-cycle flush pulse.
- branch_cnt  output  CNT_W  number of resolved branches, saturating.
- mispred_cnt  output  CNT_W  number of mispredicted branches, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - Read and write pointers, count, all upd_* outputs, mispredict, branch_cnt and mispred_cnt go to 0.
  - empty=1, full=0.
  - Entry contents are don't-care.
- Storage: circular buffer of DEPTH entries {idx, pred}. Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
- full, empty and count are combinational from the registered state.
- Push acceptance: accepted iff push=1 and full=0. A push while full is silently dropped: no state change.
- Resolve acceptance: accepted iff resolve=1 and empty=0. A resolve while empty is ignored: no update, no counter change, upd_branch=0 next cycle.
- On an accepted resolve at edge N, the following are valid for exactly cycle N+1:
  - upd_branch=1, upd_idx = head idx, upd_taken = resolve_taken.
  - mispredict = (head pred != resolve_taken).
  - When no resolve was accepted, upd_branch=0 and mispredict=0; upd_idx and upd_taken hold their last values.
- Statistics:
  - branch_cnt increments on every accepted resolve.
  - mispred_cnt increments on every accepted mispredicting resolve.
  - Both saturate at 2**CNT_W-1 and never wrap.
- Queue update on an accepted resolve that is correct:
  - Head pops (read pointer +1).
  - A same-cycle accepted push is written normally.
  - Net count change is 0 when both happen.
- Queue update on an accepted resolve that mispredicts:
  - The whole queue is flushed at that edge: write pointer = read pointer + 1, count = 0.
  - Any same-cycle push is discarded, because it is younger than the mispredicted branch.
- Simultaneous push and resolve while full:
  - Push is rejected because full=0 is required.
  - Resolve proceeds and the queue goes to DEPTH-1.
- Simultaneous push and resolve while empty: push is accepted, resolve is ignored, count becomes 1.
- Latency:
  - A pushed entry can be resolved in the cycle after its push edge.
  - Update output appears one cycle after the resolve edge.
- No combinational path from any input to any output except through the registered state used by full, empty and count.

Test Plan:
- Reset, then push idx=3 pred=1, next cycle resolve taken=1 -> following cycle: upd_branch=1, upd_idx=3, upd_taken=1, mispredict=0, branch_cnt=1, mispred_cnt=0, empty=1.
- Push 4 entries (idx 1..4, pred 0) with DEPTH=4 -> full=1, count=4; a 5th push is dropped; four resolves with taken=0 -> upd_idx sequence 1,2,3,4, no mispredict, count=0.
- Push idx 5 pred=0, idx 6 pred=1, idx 7 pred=1; resolve taken=1 on the first -> mispredict=1 for one cycle, mispred_cnt=1, count=0; idx 6 and 7 never appear on upd_idx.
- Full queue, assert push and a correct resolve together -> push rejected, count=3. Empty queue, push and resolve together -> count=1, upd_branch=0.
- Run 10 full fill/drain cycles -> pointers wrap; upd_idx order is preserved across the wrap.
- CNT_W=3: 9 mispredicting resolves -> mispred_cnt=7 and branch_cnt=7, both holding. Assert reset mid-stream with count=2 -> all outputs 0 immediately, without waiting for clk.
